// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the radix-4 FFT datapath.
// Rounding, shifting and saturation are done on a wide signed carrier.
package fft_pkg;

  localparam int DEF_SIZE_TW = 16;
  localparam int TW_FRAC     = DEF_SIZE_TW - 2;
  localparam int WMAX        = 64;

  localparam logic FWD = 1'b0;
  localparam logic INV = 1'b1;

  typedef logic signed [WMAX-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t val;
  } sat_t;

  // Clamp v into the signed range of a w-bit word and flag clipping.
  function automatic sat_t sat_trunc(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    sat_t  s;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    s.ovf = 1'b0;
    s.val = v;
    if (v > hi) begin
      s.val = hi;
      s.ovf = 1'b1;
    end else if (v < lo) begin
      s.val = lo;
      s.ovf = 1'b1;
    end
    return s;
  endfunction

  // Round half-up, then arithmetic shift right by sh.
  function automatic wide_t rnd_shift(input wide_t v, input int sh);
    wide_t r;
    r = '0;
    if (sh > 0) begin
      r = wide_t'(1) <<< (sh - 1);
    end
    return (v + r) >>> sh;
  endfunction

  // Round, shift and saturate in one step; ovf reports clipping.
  function automatic wide_t sat_rnd(input wide_t v, input int sh,
                                    input int w, output logic ovf);
    sat_t s;
    s   = sat_trunc(rnd_shift(v, sh), w);
    ovf = s.ovf;
    return s.val;
  endfunction

endpackage

// File: rtl/cmplx_mul_rnd.sv
// Registered complex multiply by a Q2 twiddle with rounding and saturation.
// ovf_o flags a clip on the product being loaded this cycle.
module cmplx_mul_rnd
  import fft_pkg::*;
#(
  parameter int SIZE_DATA = 16,
  parameter int SIZE_TW   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic signed [SIZE_DATA-1:0] re_i,
  input  logic signed [SIZE_DATA-1:0] im_i,
  input  logic signed [SIZE_TW-1:0]   tw_re_i,
  input  logic signed [SIZE_TW-1:0]   tw_im_i,
  output logic signed [SIZE_DATA-1:0] re_o,
  output logic signed [SIZE_DATA-1:0] im_o,
  output logic                        ovf_o
);

  localparam int PW = SIZE_DATA + SIZE_TW + 1;
  localparam int FR = SIZE_TW - 2;

  logic signed [PW-1:0]        prod_re;
  logic signed [PW-1:0]        prod_im;
  logic signed [SIZE_DATA-1:0] re_d;
  logic signed [SIZE_DATA-1:0] im_d;
  logic signed [SIZE_DATA-1:0] re_q;
  logic signed [SIZE_DATA-1:0] im_q;
  logic                        ovf_re;
  logic                        ovf_im;

  // (a+jb)(c+jd) at full width, then scale back to data format.
  always_comb begin
    prod_re = PW'(re_i) * PW'(tw_re_i) - PW'(im_i) * PW'(tw_im_i);
    prod_im = PW'(re_i) * PW'(tw_im_i) + PW'(im_i) * PW'(tw_re_i);
    re_d = SIZE_DATA'(sat_rnd(wide_t'(prod_re), FR, SIZE_DATA, ovf_re));
    im_d = SIZE_DATA'(sat_rnd(wide_t'(prod_im), FR, SIZE_DATA, ovf_im));
    ovf_o = en_i & (ovf_re | ovf_im);
  end

  // Result register, loads only with a valid operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en_i) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/radix4_butterfly_pipe.sv
// Pipelined radix-4 DIF butterfly: sums, scale/saturate, optional twiddle.
// Overflow is sticky; a clip in the same cycle as ovf_clr keeps it set.
module radix4_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int SIZE_DATA   = 16,
  parameter int SIZE_TW     = 16,
  parameter int SCALE       = 2,
  parameter int USE_TWIDDLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid,
  input  logic                        inverse,
  input  logic signed [SIZE_DATA-1:0] data0_in_i,
  input  logic signed [SIZE_DATA-1:0] data1_in_i,
  input  logic signed [SIZE_DATA-1:0] data2_in_i,
  input  logic signed [SIZE_DATA-1:0] data3_in_i,
  input  logic signed [SIZE_DATA-1:0] data0_in_q,
  input  logic signed [SIZE_DATA-1:0] data1_in_q,
  input  logic signed [SIZE_DATA-1:0] data2_in_q,
  input  logic signed [SIZE_DATA-1:0] data3_in_q,
  input  logic signed [SIZE_TW-1:0]   tw1_i,
  input  logic signed [SIZE_TW-1:0]   tw2_i,
  input  logic signed [SIZE_TW-1:0]   tw3_i,
  input  logic signed [SIZE_TW-1:0]   tw1_q,
  input  logic signed [SIZE_TW-1:0]   tw2_q,
  input  logic signed [SIZE_TW-1:0]   tw3_q,
  input  logic                        ovf_clr,
  output logic signed [SIZE_DATA-1:0] data0_out_i,
  output logic signed [SIZE_DATA-1:0] data1_out_i,
  output logic signed [SIZE_DATA-1:0] data2_out_i,
  output logic signed [SIZE_DATA-1:0] data3_out_i,
  output logic signed [SIZE_DATA-1:0] data0_out_q,
  output logic signed [SIZE_DATA-1:0] data1_out_q,
  output logic signed [SIZE_DATA-1:0] data2_out_q,
  output logic signed [SIZE_DATA-1:0] data3_out_q,
  output logic                        complete,
  output logic                        overflow
);

  localparam int SW = SIZE_DATA + 2;

  if (SCALE < 0 || SCALE > 2) begin : g_bad_scale
    $error("radix4_butterfly_pipe: SCALE must be 0, 1 or 2");
  end

  logic signed [SW-1:0]        xi [4];
  logic signed [SW-1:0]        xq [4];
  logic signed [SIZE_TW-1:0]   twi[3];
  logic signed [SIZE_TW-1:0]   twq[3];

  assign xi[0] = SW'(data0_in_i);
  assign xi[1] = SW'(data1_in_i);
  assign xi[2] = SW'(data2_in_i);
  assign xi[3] = SW'(data3_in_i);
  assign xq[0] = SW'(data0_in_q);
  assign xq[1] = SW'(data1_in_q);
  assign xq[2] = SW'(data2_in_q);
  assign xq[3] = SW'(data3_in_q);
  assign twi[0] = tw1_i;
  assign twi[1] = tw2_i;
  assign twi[2] = tw3_i;
  assign twq[0] = tw1_q;
  assign twq[1] = tw2_q;
  assign twq[2] = tw3_q;

  logic signed [SW-1:0] s02i, s02q, d02i, d02q;
  logic signed [SW-1:0] s13i, s13q, d13i, d13q;
  logic signed [SW-1:0] s1_i_d[4];
  logic signed [SW-1:0] s1_q_d[4];

  // Butterfly kernel; inverse swaps the roles of X1 and X3.
  always_comb begin
    s02i = xi[0] + xi[2];
    s02q = xq[0] + xq[2];
    d02i = xi[0] - xi[2];
    d02q = xq[0] - xq[2];
    s13i = xi[1] + xi[3];
    s13q = xq[1] + xq[3];
    d13i = xi[1] - xi[3];
    d13q = xq[1] - xq[3];
    s1_i_d[0] = s02i + s13i;
    s1_q_d[0] = s02q + s13q;
    s1_i_d[2] = s02i - s13i;
    s1_q_d[2] = s02q - s13q;
    if (inverse == INV) begin
      s1_i_d[1] = d02i - d13q;
      s1_q_d[1] = d02q + d13i;
      s1_i_d[3] = d02i + d13q;
      s1_q_d[3] = d02q - d13i;
    end else begin
      s1_i_d[1] = d02i + d13q;
      s1_q_d[1] = d02q - d13i;
      s1_i_d[3] = d02i - d13q;
      s1_q_d[3] = d02q + d13i;
    end
  end

  logic                      s1_v_q;
  logic signed [SW-1:0]      s1_i_q  [4];
  logic signed [SW-1:0]      s1_q_q  [4];
  logic signed [SIZE_TW-1:0] s1_twi_q[3];
  logic signed [SIZE_TW-1:0] s1_twq_q[3];

  // Stage 1 register: full-width sums plus their twiddles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s1_i_q[k] <= '0;
        s1_q_q[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        s1_twi_q[k] <= '0;
        s1_twq_q[k] <= '0;
      end
    end else begin
      s1_v_q <= valid;
      if (valid) begin
        for (int k = 0; k < 4; k++) begin
          s1_i_q[k] <= s1_i_d[k];
          s1_q_q[k] <= s1_q_d[k];
        end
        for (int k = 0; k < 3; k++) begin
          s1_twi_q[k] <= twi[k];
          s1_twq_q[k] <= twq[k];
        end
      end
    end
  end

  logic signed [SIZE_DATA-1:0] s2_i_d[4];
  logic signed [SIZE_DATA-1:0] s2_q_d[4];
  logic [3:0]                  so_i;
  logic [3:0]                  so_q;
  logic                        sat2;
  logic                        sat3;

  // Per-stage scaling with rounding, then clamp to data width.
  always_comb begin
    sat2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s2_i_d[k] = SIZE_DATA'(sat_rnd(wide_t'(s1_i_q[k]), SCALE,
                                     SIZE_DATA, so_i[k]));
      s2_q_d[k] = SIZE_DATA'(sat_rnd(wide_t'(s1_q_q[k]), SCALE,
                                     SIZE_DATA, so_q[k]));
      sat2 = sat2 | (s1_v_q & (so_i[k] | so_q[k]));
    end
  end

  logic                        s2_v_q;
  logic signed [SIZE_DATA-1:0] s2_i_q  [4];
  logic signed [SIZE_DATA-1:0] s2_q_q  [4];
  logic signed [SIZE_TW-1:0]   s2_twi_q[3];
  logic signed [SIZE_TW-1:0]   s2_twq_q[3];

  // Stage 2 register: scaled results and twiddles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s2_i_q[k] <= '0;
        s2_q_q[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        s2_twi_q[k] <= '0;
        s2_twq_q[k] <= '0;
      end
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        for (int k = 0; k < 4; k++) begin
          s2_i_q[k] <= s2_i_d[k];
          s2_q_q[k] <= s2_q_d[k];
        end
        for (int k = 0; k < 3; k++) begin
          s2_twi_q[k] <= s1_twi_q[k];
          s2_twq_q[k] <= s1_twq_q[k];
        end
      end
    end
  end

  if (USE_TWIDDLE != 0) begin : g_tw
    logic signed [SIZE_DATA-1:0] y_i[3];
    logic signed [SIZE_DATA-1:0] y_q[3];
    logic [2:0]                  y_ovf;
    logic                        s3_v_q;
    logic signed [SIZE_DATA-1:0] x0_i_q;
    logic signed [SIZE_DATA-1:0] x0_q_q;

    for (genvar k = 0; k < 3; k++) begin : g_mul
      cmplx_mul_rnd #(
        .SIZE_DATA (SIZE_DATA),
        .SIZE_TW   (SIZE_TW)
      ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (s2_v_q),
        .re_i    (s2_i_q[k+1]),
        .im_i    (s2_q_q[k+1]),
        .tw_re_i (s2_twi_q[k]),
        .tw_im_i (s2_twq_q[k]),
        .re_o    (y_i[k]),
        .im_o    (y_q[k]),
        .ovf_o   (y_ovf[k])
      );
    end

    // X0 bypasses the multiply and is delayed to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_v_q <= 1'b0;
        x0_i_q <= '0;
        x0_q_q <= '0;
      end else begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          x0_i_q <= s2_i_q[0];
          x0_q_q <= s2_q_q[0];
        end
      end
    end

    assign sat3        = |y_ovf;
    assign data0_out_i = x0_i_q;
    assign data0_out_q = x0_q_q;
    assign data1_out_i = y_i[0];
    assign data1_out_q = y_q[0];
    assign data2_out_i = y_i[1];
    assign data2_out_q = y_q[1];
    assign data3_out_i = y_i[2];
    assign data3_out_q = y_q[2];
    assign complete    = s3_v_q;
  end else begin : g_notw
    assign sat3        = 1'b0;
    assign data0_out_i = s2_i_q[0];
    assign data0_out_q = s2_q_q[0];
    assign data1_out_i = s2_i_q[1];
    assign data1_out_q = s2_q_q[1];
    assign data2_out_i = s2_i_q[2];
    assign data2_out_q = s2_q_q[2];
    assign data3_out_i = s2_i_q[3];
    assign data3_out_q = s2_q_q[3];
    assign complete    = s2_v_q;
  end

  logic ovf_q;

  // Sticky overflow; a new clip outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (sat2 | sat3) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;

endmodule
